// File: rtl/fp_arb_pkg.sv
// Shared types and the round-robin pick helper for the FP16 adder arbiter.
// Tag ids are sized for the largest supported requester count (8).
package fp_arb_pkg;

   localparam int FP16_W   = 16;
   localparam int MAX_REQ  = 8;
   localparam int TAG_ID_W = 3;
   localparam int TAG_W    = TAG_ID_W + 1;

   typedef struct packed {
      logic                valid;
      logic [TAG_ID_W-1:0] id;
   } tag_t;

   // Scan nearest-last so the first requester at or after ptr wins
   function automatic tag_t rr_pick(
      input logic [MAX_REQ-1:0]  req,
      input logic [TAG_ID_W-1:0] ptr,
      input int                  n
   );
      tag_t r;
      int   j;
      r = '0;
      for (int k = MAX_REQ - 1; k >= 0; k--) begin
         if (k < n) begin
            j = int'(ptr) + k;
            if (j >= n) j = j - n;
            if (req[j]) begin
               r.valid = 1'b1;
               r.id    = j[TAG_ID_W-1:0];
            end
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/fp_arb_tag_pipe.sv
// Enabled shift register carrying request tags in lockstep with the adder.
module fp_arb_tag_pipe #(
   parameter int DEPTH = 5,
   parameter int W     = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      i_en,
   input  logic [W-1:0]              i_d,
   output logic [W-1:0]              o_q,
   output logic [DEPTH-1:0][W-1:0]   o_stages
);

   logic [DEPTH-1:0][W-1:0] r_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_q <= '0;
      end else if (i_en) begin
         r_q[0] <= i_d;
         for (int k = 1; k < DEPTH; k++) begin
            r_q[k] <= r_q[k-1];
         end
      end
   end

   assign o_q      = r_q[DEPTH-1];
   assign o_stages = r_q;

endmodule

// File: rtl/fp_adder_arbiter.sv
// Round-robin sharing of one pipelined FP16 adder among NUM_REQ requesters.
// Optional perf counters: define FPADD_ARB_PERF_EN.
module fp_adder_arbiter
   import fp_arb_pkg::*;
#(
   parameter int NUM_REQ     = 4,
   parameter int DATA_WIDTH  = FP16_W,
   parameter int ADD_LATENCY = 5
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_REQ-1:0]            req_valid,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
   output logic [NUM_REQ-1:0]            rsp_valid,
   input  logic [NUM_REQ-1:0]            rsp_ready,
   output logic [DATA_WIDTH-1:0]         rsp_data,
   output logic                          add_en,
   output logic [DATA_WIDTH-1:0]         add_a,
   output logic [DATA_WIDTH-1:0]         add_b,
   input  logic [DATA_WIDTH-1:0]         add_result,
`ifdef FPADD_ARB_PERF_EN
   output logic [31:0]                   perf_issue_cnt,
   output logic [31:0]                   perf_stall_cnt,
   output logic [31:0]                   perf_idle_cnt,
`endif
   output logic                          busy
);

   localparam int ID_W = $clog2(NUM_REQ);

   logic [ID_W-1:0]                     r_ptr;
   logic [MAX_REQ-1:0]                  w_req_x;
   logic [MAX_REQ-1:0]                  w_rdy_x;
   logic                                w_stall;
   tag_t                                w_pick;
   tag_t                                w_grant;
   tag_t                                w_tag_out;
   logic [ADD_LATENCY-1:0][TAG_W-1:0]   w_stages;

   assign w_req_x = MAX_REQ'(req_valid);
   assign w_rdy_x = MAX_REQ'(rsp_ready);
   assign w_stall = w_tag_out.valid & ~w_rdy_x[w_tag_out.id];
   assign add_en  = ~w_stall;
   assign w_pick  = rr_pick(w_req_x, TAG_ID_W'(r_ptr), NUM_REQ);

   always_comb begin
      w_grant       = w_pick;
      w_grant.valid = w_pick.valid & ~w_stall & ~reset;
   end

   always_comb begin
      req_ready = '0;
      add_a     = '0;
      add_b     = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_grant.valid && w_grant.id == TAG_ID_W'(i)) begin
            req_ready[i] = 1'b1;
            add_a        = req_a[i*DATA_WIDTH +: DATA_WIDTH];
            add_b        = req_b[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ptr <= '0;
      end else if (w_grant.valid) begin
         if (w_grant.id == TAG_ID_W'(NUM_REQ - 1)) r_ptr <= '0;
         else r_ptr <= ID_W'(w_grant.id + 1'b1);
      end
   end

   fp_arb_tag_pipe #(
      .DEPTH (ADD_LATENCY),
      .W     (TAG_W)
   ) u_tags (
      .clk      (clk),
      .reset    (reset),
      .i_en     (add_en),
      .i_d      (w_grant),
      .o_q      (w_tag_out),
      .o_stages (w_stages)
   );

   always_comb begin
      rsp_valid = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         rsp_valid[i] = w_tag_out.valid & (w_tag_out.id == TAG_ID_W'(i));
      end
   end

   assign rsp_data = add_result;

   always_comb begin
      busy = 1'b0;
      for (int k = 0; k < ADD_LATENCY; k++) begin
         busy = busy | w_stages[k][TAG_W-1];
      end
   end

`ifdef FPADD_ARB_PERF_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         perf_issue_cnt <= '0;
         perf_stall_cnt <= '0;
         perf_idle_cnt  <= '0;
      end else begin
         if (w_grant.valid && perf_issue_cnt != '1)
            perf_issue_cnt <= perf_issue_cnt + 32'd1;
         if (w_stall && perf_stall_cnt != '1)
            perf_stall_cnt <= perf_stall_cnt + 32'd1;
         if (!busy && req_valid == '0 && perf_idle_cnt != '1)
            perf_idle_cnt <= perf_idle_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fp_adder_arbiter.sv
// Bench for fp_adder_arbiter: directed traffic, timestamp scoreboard model,
// and a behavioural 5-stage FP16 adder (positive normals, truncating).
module tb_fp_adder_arbiter;

   localparam int N = 4;
   localparam int L = 5;

   logic          clk = 1'b0;
   logic          reset;
   logic [N-1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
   logic [N*16-1:0] req_a, req_b;
   logic [15:0]   rsp_data, add_a, add_b, add_result;
   logic          add_en, busy;
`ifdef FPADD_ARB_PERF_EN
   logic [31:0]   perf_issue_cnt, perf_stall_cnt, perf_idle_cnt;
`endif

   fp_adder_arbiter #(
      .NUM_REQ(N), .DATA_WIDTH(16), .ADD_LATENCY(L)
   ) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .add_en(add_en), .add_a(add_a), .add_b(add_b),
      .add_result(add_result),
`ifdef FPADD_ARB_PERF_EN
      .perf_issue_cnt(perf_issue_cnt),
      .perf_stall_cnt(perf_stall_cnt),
      .perf_idle_cnt(perf_idle_cnt),
`endif
      .busy(busy)
   );

   always #5 clk = ~clk;

   int nchk = 0;
   int nerr = 0;
   int cyc  = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [15:0] fadd(input logic [15:0] a,
                                        input logic [15:0] b);
      int ea, eb, ma, mb, s, t;
      ea = int'(a[14:10]); eb = int'(b[14:10]);
      ma = 1024 + int'(a[9:0]); mb = 1024 + int'(b[9:0]);
      if (eb > ea) begin
         t = ea; ea = eb; eb = t;
         t = ma; ma = mb; mb = t;
      end
      mb = (ea - eb > 11) ? 0 : (mb >> (ea - eb));
      s = ma + mb;
      if (s >= 2048) begin
         s = s >> 1;
         ea++;
      end
      return {1'b0, ea[4:0], s[9:0]};
   endfunction

   // behavioural shared adder
   logic [15:0] apipe [L];
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < L; k++) apipe[k] <= '0;
      end else if (add_en) begin
         apipe[0] <= fadd(add_a, add_b);
         for (int k = 1; k < L; k++) apipe[k] <= apipe[k-1];
      end
   end
   assign add_result = apipe[L-1];

   // scoreboard: each op completes L enabled edges after issue
   typedef struct {
      int          id;
      logic [15:0] res;
      int          t;
   } op_t;
   op_t mq[$];
   int  mptr = 0;
   int  men  = 0;

   initial begin
      bit due, stl;
      int g, idx;
      logic [N-1:0] er, ev;
      logic [15:0] ea, eb;
      op_t o;
      forever begin
         @(negedge clk);
         if (reset) begin
            mq.delete();
            mptr = 0;
            men  = 0;
            chk("rst_req_ready", req_ready, 0);
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_busy", busy, 0);
            chk("rst_add_en", add_en, 1);
            chk("rst_add_a", add_a, 0);
            chk("rst_add_b", add_b, 0);
         end else begin
            due = (mq.size() > 0) && (mq[0].t + L == men);
            stl = due && !rsp_ready[mq[0].id];
            g = -1;
            if (!stl) begin
               for (int k = N - 1; k >= 0; k--) begin
                  idx = (mptr + k) % N;
                  if (req_valid[idx]) g = idx;
               end
            end
            er = '0; ev = '0; ea = '0; eb = '0;
            if (g >= 0) begin
               er[g] = 1'b1;
               ea = req_a[g*16 +: 16];
               eb = req_b[g*16 +: 16];
            end
            if (due) ev[mq[0].id] = 1'b1;
            chk("req_ready", req_ready, er);
            chk("rsp_valid", rsp_valid, ev);
            chk("add_en", add_en, !stl);
            chk("busy", busy, mq.size() > 0);
            chk("add_a", add_a, ea);
            chk("add_b", add_b, eb);
            if (due) chk("rsp_data", rsp_data, mq[0].res);
            @(posedge clk);
            if (!stl) begin
               if (due) void'(mq.pop_front());
               if (g >= 0) begin
                  o.id = g; o.res = fadd(ea, eb); o.t = men;
                  mq.push_back(o);
                  mptr = (g + 1) % N;
               end
               men++;
            end
         end
      end
   end

   // stimulus driver state and logs
   int left [N];
   int seqn [N];
   int bp_id, bp_left, nstall, nrdy_stall;
   int gord[$], icyc[$], rord[$], rcyc[$];
   logic [15:0] rdata[$];
   logic [N-1:0] rvec[$];

   task automatic set_ops(input int i);
      req_a[i*16 +: 16] = 16'h3C00 + 16'(seqn[i] * 64 + i * 256);
      req_b[i*16 +: 16] = 16'h3C00 + 16'(seqn[i] * 32);
   endtask

   task automatic start(input int i, input int n);
      left[i] = n;
      seqn[i] = 0;
      set_ops(i);
      req_valid[i] = (n > 0);
   endtask

   task automatic clr_logs();
      gord.delete(); icyc.delete(); rord.delete();
      rcyc.delete(); rdata.delete(); rvec.delete();
      nstall = 0; nrdy_stall = 0;
   endtask

   task automatic step();
      logic [N-1:0] hs;
      @(negedge clk);
      hs = req_valid & req_ready;
      for (int i = 0; i < N; i++) begin
         if (hs[i]) begin
            gord.push_back(i);
            icyc.push_back(cyc);
         end
         if (rsp_valid[i] && rsp_ready[i]) begin
            rord.push_back(i);
            rcyc.push_back(cyc);
            rdata.push_back(rsp_data);
            rvec.push_back(rsp_valid);
         end
      end
      if (!add_en) begin
         nstall++;
         if (req_ready != 0) nrdy_stall++;
      end
      if (bp_id >= 0 && rsp_valid[bp_id] && bp_left > 0) bp_left--;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
         if (hs[i]) begin
            left[i]--;
            seqn[i]++;
            set_ops(i);
            req_valid[i] = (left[i] > 0);
         end
      end
      if (bp_id >= 0 && bp_left == 0) begin
         rsp_ready[bp_id] = 1'b1;
         bp_id = -1;
      end
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      while ((req_valid != 0 || busy) && n < budget) begin
         step();
         n++;
      end
      if (n >= budget) begin
         nchk++;
         nerr++;
         $display("FAIL drain: timed out after %0d cycles", n);
      end
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      req_valid = '0;
      rsp_ready = '1;
      bp_id = -1;
      for (int i = 0; i < N; i++) left[i] = 0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int c1;
      reset = 1'b1;
      req_valid = '0;
      req_a = '0;
      req_b = '0;
      rsp_ready = '1;
      bp_id = -1;
      bp_left = 0;
      for (int i = 0; i < N; i++) begin
         left[i] = 0;
         seqn[i] = 0;
      end
      clr_logs();
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      chk("model_fadd", fadd(req_a[15:0] | 16'h3C00, 16'h4000), 16'h4200);

      // single issue
      clr_logs();
      start(0, 1);
      drain(50);
      chk("t1_count", rord.size(), 1);
      chk("t1_grant", gord[0], 0);
      chk("t1_latency", rcyc[0] - icyc[0], 5);
      chk("t1_data", rdata[0], 16'h4000);
      chk("t1_vec", rvec[0], 4'b0001);

      // contention from pointer 0
      apply_reset();
      clr_logs();
      for (int i = 0; i < N; i++) start(i, 1);
      drain(50);
      for (int k = 0; k < N; k++) begin
         chk("t2_grant_order", gord[k], k);
         chk("t2_rsp_order", rord[k], k);
         chk("t2_rsp_cycle", rcyc[k] - icyc[0], 5 + k);
      end

      // backpressure on requester 1 for 3 cycles
      apply_reset();
      clr_logs();
      rsp_ready = 4'b1101;
      bp_id = 1;
      bp_left = 3;
      start(0, 6);
      for (int i = 1; i < N; i++) start(i, 1);
      drain(80);
      chk("t3_stall_cycles", nstall, 3);
      chk("t3_ready_in_stall", nrdy_stall, 0);
      chk("t3_total_rsp", rord.size(), 9);
      c1 = 0;
      foreach (rord[k]) if (rord[k] == 1) c1++;
      chk("t3_req1_rsp", c1, 1);
`ifdef FPADD_ARB_PERF_EN
      chk("perf_issue", perf_issue_cnt, 9);
      chk("perf_stall", perf_stall_cnt, 3);
`endif

      // sustained throughput from requester 2
      clr_logs();
      start(2, 20);
      drain(100);
      chk("t4_count", rord.size(), 20);
      chk("t4_span", rcyc[19] - rcyc[0], 19);
      chk("t4_latency", rcyc[0] - icyc[0], 5);

      // reset with operations in flight
      clr_logs();
      for (int i = 0; i < 3; i++) start(i, 1);
      repeat (3) step();
      chk("t5_inflight", gord.size(), 3);
      apply_reset();
      clr_logs();
      repeat (10) step();
      chk("t5_busy_after", busy, 0);
      chk("t5_no_rsp", rord.size(), 0);
      clr_logs();
      start(3, 1);
      drain(50);
      chk("t5_new_count", rord.size(), 1);
      chk("t5_new_latency", rcyc[0] - icyc[0], 5);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
